// File: rtl/s2vfish_pkg.sv
// Shared types and helpers for the cipher fabric: bridge FSM states, block/word
// geometry and the big-endian word ordering used on the PIO side.
package s2vfish_pkg;

  localparam int BLOCK_W = 128;
  localparam int WORD_W  = 32;

  localparam logic ENDE_ENC = 1'b1;
  localparam logic ENDE_DEC = 1'b0;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} bridge_state_t;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [BLOCK_W-1:0] block_t;

  // word0 is the most significant word of the 128-bit value
  function automatic block_t pack4(input word_t w0, input word_t w1,
                                   input word_t w2, input word_t w3);
    return {w0, w1, w2, w3};
  endfunction

  function automatic word_t unpack4(input block_t b, input logic [1:0] idx);
    word_t w;
    case (idx)
      2'd0:    w = b[127:96];
      2'd1:    w = b[95:64];
      2'd2:    w = b[63:32];
      default: w = b[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/pio_rise_detect.sv
// Rising-edge detector for a software PIO level. The delayed copy resets high so
// a level already asserted across reset is not seen as a fresh edge.
module pio_rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic level_d;

  always_ff @(posedge clk) begin
    if (!rst_n) level_d <= 1'b1;
    else        level_d <= level;
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/cipher_pio_bridge.sv
// Fabric endpoint between the soft-core PIOs and the cipher core: latches the
// operands on a start edge, pulses the core, and holds the result for software.
module cipher_pio_bridge #(
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                soft_reset,
  input  logic                start,
  input  logic                ende,
  input  logic [WORD_W-1:0]   key0,
  input  logic [WORD_W-1:0]   key1,
  input  logic [WORD_W-1:0]   key2,
  input  logic [WORD_W-1:0]   key3,
  input  logic [WORD_W-1:0]   block0,
  input  logic [WORD_W-1:0]   block1,
  input  logic [WORD_W-1:0]   block2,
  input  logic [WORD_W-1:0]   block3,
  output logic                busy,
  output logic                err,
  output logic [WORD_W-1:0]   out0,
  output logic [WORD_W-1:0]   out1,
  output logic [WORD_W-1:0]   out2,
  output logic [WORD_W-1:0]   out3,
  output logic                core_start,
  output logic                core_ende,
  output logic [4*WORD_W-1:0] core_key,
  output logic [4*WORD_W-1:0] core_block,
  input  logic                core_done,
  input  logic [4*WORD_W-1:0] core_result
);

  import s2vfish_pkg::*;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  bridge_state_t       state, state_nx;
  logic                rst_n;
  logic                rise;
  logic                timeout_hit;
  logic [CNT_W-1:0]    cnt;
  logic [4*WORD_W-1:0] res;

  // Hardware and software resets are indistinguishable to the bridge
  assign rst_n = reset_reset_n & ~soft_reset;

  pio_rise_detect u_start_rise (
    .clk   (clk_clk),
    .rst_n (rst_n),
    .level (start),
    .rise  (rise)
  );

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (rise) state_nx = LAUNCH;
      LAUNCH:  state_nx = WAIT;
      WAIT:    if (core_done || timeout_hit) state_nx = DONE;
      DONE:    if (!start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    core_start = 1'b0;
    if (state == LAUNCH) core_start = 1'b1;
  end

  // Operands are captured only on a launch, so PIO traffic mid-operation
  // never reaches the core.
  always_ff @(posedge clk_clk) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      err        <= 1'b0;
      core_ende  <= 1'b0;
      core_key   <= '0;
      core_block <= '0;
      res        <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (rise) begin
          core_key   <= pack4(key0, key1, key2, key3);
          core_block <= pack4(block0, block1, block2, block3);
          core_ende  <= ende;
          busy       <= 1'b1;
          err        <= 1'b0;
        end
        LAUNCH: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          // done beats a timeout landing on the same cycle
          if (core_done) begin
            res  <= core_result;
            busy <= 1'b0;
          end else if (timeout_hit) begin
            res  <= '0;
            err  <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out0 = unpack4(res, 2'd0);
  assign out1 = unpack4(res, 2'd1);
  assign out2 = unpack4(res, 2'd2);
  assign out3 = unpack4(res, 2'd3);

endmodule

// File: tb/tb_cipher_pio_bridge.sv
// Randomized bench for cipher_pio_bridge with an operation-level reference
// model and a per-cycle compare process.
module tb_cipher_pio_bridge;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset_reset_n, soft_reset, start, ende;
  logic [31:0]  key0, key1, key2, key3, block0, block1, block2, block3;
  logic         busy, err, core_start, core_ende, core_done;
  logic [31:0]  out0, out1, out2, out3;
  logic [127:0] core_key, core_block, core_result;

  always #5 clk = ~clk;

  cipher_pio_bridge #(.WORD_W(32), .TIMEOUT(TO)) dut (
    .clk_clk(clk), .reset_reset_n(reset_reset_n), .soft_reset(soft_reset),
    .start(start), .ende(ende),
    .key0(key0), .key1(key1), .key2(key2), .key3(key3),
    .block0(block0), .block1(block1), .block2(block2), .block3(block3),
    .busy(busy), .err(err), .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .core_start(core_start), .core_ende(core_ende), .core_key(core_key),
    .core_block(core_block), .core_done(core_done), .core_result(core_result)
  );

  int errors = 0;
  int checks = 0;
  int cs_count = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: an operation is either running (launched at cycle
  // launch_c, deadline launch_c+TO) or finished and waiting for start to drop.
  longint       cur = 0;
  longint       launch_c = -10;
  bit           running = 0, hold = 0, start_prev = 1;
  logic         m_busy = 0, m_err = 0, m_ende = 0;
  logic [127:0] m_out = '0, m_key = '0, m_block = '0;

  always @(posedge clk) begin
    if (!reset_reset_n || soft_reset) begin
      running = 0; hold = 0; m_busy = 0; m_err = 0; m_ende = 0;
      m_out = '0; m_key = '0; m_block = '0;
      start_prev = 1;
    end else begin
      if (running) begin
        if (cur > launch_c && core_done) begin
          m_out = core_result; m_busy = 0; running = 0; hold = 1;
        end else if (cur == launch_c + TO) begin
          m_out = '0; m_err = 1; m_busy = 0; running = 0; hold = 1;
        end
      end else if (hold) begin
        if (!start) hold = 0;
      end else if (start && !start_prev) begin
        m_key   = {key0, key1, key2, key3};
        m_block = {block0, block1, block2, block3};
        m_ende  = ende;
        m_busy  = 1; m_err = 0; running = 1;
        launch_c = cur + 1;
      end
      start_prev = start;
    end
    cur++;
  end

  always @(negedge clk) begin
    if (core_start) cs_count++;
    if (chk_en) begin
      chk("busy", 128'(busy), 128'(m_busy));
      chk("err", 128'(err), 128'(m_err));
      chk("out", {out0, out1, out2, out3}, m_out);
      chk("core_start", 128'(core_start), 128'(running && cur == launch_c));
      chk("core_ende", 128'(core_ende), 128'(m_ende));
      chk("core_key", core_key, m_key);
      chk("core_block", core_block, m_block);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rand_words();
    key0 = $urandom; key1 = $urandom; key2 = $urandom; key3 = $urandom;
    block0 = $urandom; block1 = $urandom; block2 = $urandom; block3 = $urandom;
    ende = 1'($urandom_range(0, 1));
  endtask

  // Raise start, answer the launch with done after lat cycles (0 = silent),
  // optionally toggle start and change operands while the core is working.
  task automatic run_op(input int lat, input logic [127:0] res, input bit toggle);
    bit seen = 0;
    int n;
    start = 1'b1;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (core_start) seen = 1;
    end
    if (!seen) begin
      errors++; checks++;
      $display("FAIL launch_wait: core_start=0 after 4 cycles, required 1");
      return;
    end
    n = (lat == 0) ? TO + 2 : lat;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      core_done = (k == lat);
      if (k == lat) core_result = res;
      if (toggle && k == 2) start = 1'b0;
      if (toggle && k == 3) begin start = 1'b1; rand_words(); end
    end
    @(negedge clk);
    core_done = 1'b0;
    for (int i = 0; i < TO + 4 && busy; i++) @(negedge clk);
    if (busy) begin
      errors++; checks++;
      $display("FAIL busy_wait: busy=1 after bound, required 0");
    end
  endtask

  logic [127:0] r, saved_key;
  int c0, lat;

  initial begin
    reset_reset_n = 0; soft_reset = 0; start = 0; core_done = 0; core_result = '0;
    key0 = 0; key1 = 0; key2 = 0; key3 = 0; block0 = 0; block1 = 0; block2 = 0; block3 = 0;
    ende = 0;
    tick(2);
    chk_en = 1;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_out0", 128'(out0), 128'd0);
    chk("rst_key", core_key, 128'd0);
    reset_reset_n = 1;
    tick(2);

    // basic encrypt; 16-cycle latency lands exactly on the timeout cycle
    {key0, key1, key2, key3} = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    {block0, block1, block2, block3} = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    ende = 1;
    run_op(16, 128'hDEADBEEF_00000001_00000002_00000003, 0);
    chk("basic_out0", 128'(out0), 128'hDEADBEEF);
    chk("basic_out3", 128'(out3), 128'h3);
    chk("basic_err", 128'(err), 128'd0);
    chk("basic_key", core_key, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    chk("basic_ende", 128'(core_ende), 128'd1);
    start = 0; tick(2);
    rand_words();
    run_op(5, {$urandom, $urandom, $urandom, $urandom}, 0);
    start = 0; tick(2);

    // start held high across reset must not launch
    reset_reset_n = 0; tick(1);
    start = 1; tick(2);
    reset_reset_n = 1;
    c0 = cs_count;
    tick(6);
    chk("held_no_launch", 128'(cs_count - c0), 128'd0);
    start = 0; tick(1);
    run_op(5, {$urandom, $urandom, $urandom, $urandom}, 0);
    chk("held_relaunch", 128'(cs_count - c0), 128'd1);
    start = 0; tick(2);

    // silent core times out, next launch clears err
    run_op(0, '0, 0);
    chk("to_err", 128'(err), 128'd1);
    chk("to_out", {out0, out1, out2, out3}, 128'd0);
    start = 0; tick(1);
    run_op(3, 128'h11112222_33334444_55556666_77778888, 0);
    chk("to_clear_err", 128'(err), 128'd0);
    chk("to_next_out1", 128'(out1), 128'h33334444);
    start = 0; tick(1);

    // one cycle past the deadline the result is lost
    run_op(TO + 1, 128'hAAAA, 0);
    chk("late_err", 128'(err), 128'd1);
    chk("late_out3", 128'(out3), 128'd0);
    start = 0; tick(1);

    // start toggle and operand changes during WAIT
    rand_words();
    saved_key = {key0, key1, key2, key3};
    c0 = cs_count;
    run_op(10, 128'h12345678_9ABCDEF0_0FEDCBA9_87654321, 1);
    chk("toggle_one_launch", 128'(cs_count - c0), 128'd1);
    chk("toggle_key_stable", core_key, saved_key);
    tick(4);
    chk("done_holds", 128'(cs_count - c0), 128'd1);
    chk("done_out2", 128'(out2), 128'h0FEDCBA9);
    start = 0; tick(2);

    // soft reset mid-operation, then a stale done
    rand_words();
    start = 1; tick(4);
    soft_reset = 1; tick(1);
    soft_reset = 0; tick(2);
    core_done = 1; core_result = 128'hFFFF_0000_FFFF_0000; tick(1);
    core_done = 0; tick(1);
    chk("sr_busy", 128'(busy), 128'd0);
    chk("sr_out", {out0, out1, out2, out3}, 128'd0);
    start = 0; tick(1);
    run_op(7, {$urandom, $urandom, $urandom, $urandom}, 0);
    start = 0; tick(1);

    // randomized operations
    for (int it = 0; it < 40; it++) begin
      rand_words();
      lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO + 4));
      r = {$urandom, $urandom, $urandom, $urandom};
      run_op(lat, r, (lat >= 4) && ($urandom_range(0, 2) == 0));
      tick($urandom_range(0, 3));
      start = 0;
      if ($urandom_range(0, 3) == 0) begin
        core_done = 1; core_result = {$urandom, $urandom, $urandom, $urandom};
        tick(1);
        core_done = 0;
      end
      tick($urandom_range(1, 3));
    end

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cipher_pio_bridge.md
Name: cipher_pio_bridge

Overview:
- Fabric-side endpoint of the NIOS PIO cipher handshake.
- Accepts the 4x32-bit key and block words, the ende select and the start level from the soft-core PIOs, then launches the Twofish cipher core through a pulse/done interface.
- Drives busy back to software and holds the 128-bit result on the four 32-bit out words until the next operation.
- Sits between the NIOSsoc instance and the cipher core in the top level.

Parameters:
- WORD_W, 32, width of each PIO word.
- TIMEOUT, 4096, maximum cycles in WAIT before the operation is aborted; 0 disables the timeout.

Ports:
- clk_clk  in  1  system clock, shared with the SoC
- reset_reset_n  in  1  synchronous active-low reset
- soft_reset  in  1  software reset from the reset_1 PIO, active-high, synchronous, same effect as reset_reset_n
- start  in  1  launch level from software
- ende  in  1  1 = encrypt, 0 = decrypt
- key0..key3  in  32 each  key words; key0 = bits [127:96]
- block0..block3  in  32 each  data words; block0 = bits [127:96]
- busy  out  1  operation in progress
- err  out  1  last operation timed out
- out0..out3  out  32 each  result words; out0 = bits [127:96]
- core_start  out  1  one-cycle launch pulse to the cipher core
- core_ende  out  1  latched ende
- core_key  out  128  latched key
- core_block  out  128  latched block
- core_done  in  1  one-cycle completion pulse from the core
- core_result  in  128  valid when core_done = 1

Behaviour:
- Reset (reset_reset_n = 0 or soft_reset = 1 at a clock edge):
  - State goes to IDLE.
  - busy, err, core_start, core_ende = 0; core_key, core_block, out0..3 = 0; timeout counter = 0.
  - start_d (the registered copy of start) resets to 1. A start held high through reset therefore does not launch; software must drop it and raise it again.
- States: IDLE, LAUNCH, WAIT, DONE.
- IDLE:
  - A rising edge (start = 1, start_d = 0) in cycle T0 latches key0..3, block0..3 and ende into the core_* registers at the T0 edge.
  - At the same edge: busy <= 1, err <= 0, state goes to LAUNCH.
- LAUNCH:
  - core_start = 1 for exactly this one cycle (T0+1); counter cleared.
  - core_done is ignored in this cycle.
  - State goes to WAIT.
- WAIT:
  - Counter increments every cycle.
  - On core_done = 1: out0..3 <= core_result split into words, busy <= 0, state goes to DONE. out and busy update on the same edge, so software never sees busy = 0 with stale out.
  - Timeout: when TIMEOUT != 0 and the counter reaches TIMEOUT - 1 without core_done, out0..3 <= 0, err <= 1, busy <= 0, state goes to DONE.
  - If core_done arrives in the same cycle the counter reaches TIMEOUT - 1, done wins: result captured, err stays 0.
- DONE:
  - out, err and busy are held.
  - When start = 0, state goes to IDLE. A fresh rising edge is then required to launch again.
- start changes while busy:
  - Ignored by LAUNCH and WAIT; the operation always completes or times out.
  - A low-high toggle during WAIT does not queue a second operation.
- core_key, core_block and core_ende stay stable from LAUNCH until the next launch; key/block/ende PIO changes after T0 have no effect on the running operation.
- core_done outside WAIT is ignored.
- Reset mid-operation (any state): immediate return to the reset values above. A late core_done from the aborted operation is ignored because the bridge is no longer in WAIT.
- start_d is registered every cycle in all states.

Decomposition:
- Shared package s2vfish_pkg holds:
  - the bridge_state_t enum (IDLE, LAUNCH, WAIT, DONE);
  - BLOCK_W = 128 and WORD_W = 32;
  - ENDE_ENC = 1'b1 and ENDE_DEC = 1'b0;
  - word-order helper functions pack4 and unpack4 (word0 = most significant).
- One sub-module, pio_rise_detect: registered start_d with reset value 1, producing the rise pulse. Everything else stays in the bridge.

Test Plan:
- Basic encrypt: key = 0x00112233_44556677_8899AABB_CCDDEEFF, block = 0x01234567_89ABCDEF_FEDCBA98_76543210, ende = 1; raise start at T0 -> core_start high only at T0+1, busy = 1 from T0+1; core model returns done after 16 cycles with result 0xDEADBEEF_00000001_00000002_00000003 -> out0 = 0xDEADBEEF, out3 = 0x00000003, busy = 0 on the same edge.
- Start held high through reset, then released -> no core_start until start goes 0 then 1; second edge launches normally.
- Timeout with TIMEOUT = 8 and core silent -> busy falls 8 cycles after LAUNCH, err = 1, out0..3 = 0; the next launch clears err.
- core_done on the exact timeout cycle -> result captured, err = 0.
- Start toggled 0->1 during WAIT and key words changed mid-operation -> exactly one core_start; core_key unchanged; DONE persists until start = 0.
- soft_reset asserted in WAIT, then a late core_done -> busy = 0, out stays 0, state IDLE; a following launch works.
